// File: rtl/scm_mstat.sv
// scm_mstat: multi-channel statistics / retag stage.
// MD/PHV pairs pass through two show-ahead FIFOs and leave one cycle after the
// pop. LMID packets are retagged to NMID and counted per protocol channel
// inside a software-armed measurement window with an n_rtt grace period.
// Optional macro SCM_GRACE_TIMEOUT_EN: GRACE also exits after n_rtt cycles.
module scm_mstat #(
    parameter int          MD_W    = 256,
    parameter int          PHV_W   = 1024,
    parameter logic [7:0]  LMID    = 8'd7,
    parameter logic [7:0]  NMID    = 8'd5,
    parameter int          CH_NUM  = 4,
    parameter int          FIFO_AW = 8,
    parameter int          ALF_TH  = 250
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MD_W-1:0]   in_md,
    input  logic              in_md_wr,
    output logic              out_md_alf,
    input  logic [PHV_W-1:0]  in_phv,
    input  logic              in_phv_wr,
    output logic              out_phv_alf,
    output logic [MD_W-1:0]   out_md,
    output logic              out_md_wr,
    input  logic              in_md_alf,
    output logic [PHV_W-1:0]  out_phv,
    output logic              out_phv_wr,
    input  logic              in_phv_alf,
    input  logic              gac2scm_sent_start,
    input  logic              gac2scm_sent_end,
    input  logic              cfg2scm_cs_n,
    input  logic              cfg2scm_rw,
    input  logic [31:0]       cfg2scm_addr,
    input  logic [31:0]       cfg2scm_wdata,
    output logic              scm2cfg_ack_n,
    output logic [31:0]       scm2cfg_rdata
);

    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_GRACE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t state;

    // ---------------- input FIFOs ----------------
    logic [MD_W-1:0]    md_mem  [DEPTH];
    logic [PHV_W-1:0]   phv_mem [DEPTH];
    logic [FIFO_AW-1:0] md_wp, md_rp, phv_wp, phv_rp;
    logic [FIFO_AW:0]   md_cnt, phv_cnt;
    logic               md_push, phv_push, pop;
    logic [MD_W-1:0]    head_md;
    logic [PHV_W-1:0]   head_phv;

    // count never exceeds DEPTH, so its MSB alone flags full
    always_comb begin
        md_push     = in_md_wr  & ~md_cnt[FIFO_AW];
        phv_push    = in_phv_wr & ~phv_cnt[FIFO_AW];
        pop         = (md_cnt != '0) & (phv_cnt != '0) & ~in_md_alf & ~in_phv_alf;
        head_md     = md_mem[md_rp];
        head_phv    = phv_mem[phv_rp];
        out_md_alf  = in_md_alf  | (32'(md_cnt)  > 32'(ALF_TH));
        out_phv_alf = in_phv_alf | (32'(phv_cnt) > 32'(ALF_TH));
    end

    // FIFO storage writes
    always_ff @(posedge clk) begin
        if (md_push)  md_mem[md_wp]   <= in_md;
        if (phv_push) phv_mem[phv_wp] <= in_phv;
    end

    // FIFO pointers and fill levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_wp   <= '0;
            md_rp   <= '0;
            md_cnt  <= '0;
            phv_wp  <= '0;
            phv_rp  <= '0;
            phv_cnt <= '0;
        end else begin
            if (md_push)  md_wp  <= md_wp + 1'b1;
            if (phv_push) phv_wp <= phv_wp + 1'b1;
            if (pop) begin
                md_rp  <= md_rp + 1'b1;
                phv_rp <= phv_rp + 1'b1;
            end
            md_cnt  <= md_cnt  + {{FIFO_AW{1'b0}}, md_push}  - {{FIFO_AW{1'b0}}, pop};
            phv_cnt <= phv_cnt + {{FIFO_AW{1'b0}}, phv_push} - {{FIFO_AW{1'b0}}, pop};
        end
    end

    // ---------------- packet classification ----------------
    logic [31:0]       h_ts;
    logic [7:0]        h_proto, h_id;
    logic [11:0]       h_len;
    logic              lmid_pkt, exit_hit, grace_exit, cnt_active, timeout_hit, drop_any;
    logic [31:0]       end_ts, last_lmid_ts, n_rtt;
    logic [CH_NUM-1:0] ch_en, ch_drop, ch_hit;
    logic [7:0]        ch_proto [CH_NUM];
    logic [MD_W-1:0]   fwd_md;

`ifdef SCM_GRACE_TIMEOUT_EN
    logic [31:0] grace_cnt;

    // cycles spent in GRACE, restarted on every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                grace_cnt <= '0;
        else if (state != S_GRACE) grace_cnt <= '0;
        else                       grace_cnt <= grace_cnt + 32'd1;
    end

    // timeout exit condition
    always_comb timeout_hit = (grace_cnt >= n_rtt);
`else
    // no timeout exit in this build
    always_comb timeout_hit = 1'b0;
`endif

    // field extraction, window qualification, channel match and retag
    always_comb begin
        h_ts       = head_md[31:0];
        h_proto    = head_md[79:72];
        h_id       = head_md[87:80];
        h_len      = head_md[107:96];
        lmid_pkt   = pop & (h_id == LMID);
        exit_hit   = lmid_pkt & ({1'b0, h_ts} >= ({1'b0, end_ts} + {1'b0, n_rtt}));
        grace_exit = (state == S_GRACE) & ((n_rtt == '0) | exit_hit | timeout_hit);
        cnt_active = lmid_pkt & ((state == S_RUN) | ((state == S_GRACE) & ~grace_exit));
        for (int unsigned c = 0; c < CH_NUM; c++)
            ch_hit[c] = cnt_active & ch_en[c] & (ch_proto[c] == h_proto);
        drop_any = |(ch_hit & ch_drop);
        fwd_md   = head_md;
        if (h_id == LMID) begin
            fwd_md[87:80] = NMID;
            fwd_md[108]   = head_md[108] | drop_any;
        end
    end

    // output register: pair leaves one cycle after its pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_md     <= '0;
            out_phv    <= '0;
            out_md_wr  <= 1'b0;
            out_phv_wr <= 1'b0;
        end else begin
            out_md_wr  <= pop;
            out_phv_wr <= pop;
            if (pop) begin
                out_md  <= fwd_md;
                out_phv <= head_phv;
            end
        end
    end

    // ---------------- localbus decode ----------------
    logic        bus_acc, bus_wr, bus_rd, hi_ok, g_sel, clr_req, clr_ok, clr_rej, clr_flag;
    logic [3:0]  blk;
    logic [7:0]  off;
    logic [31:0] rd_mux;
    logic [63:0] pkt_cnt  [CH_NUM];
    logic [63:0] byte_cnt [CH_NUM];
    logic [31:0] first_ts [CH_NUM];
    logic [31:0] last_ts  [CH_NUM];
    logic [CH_NUM-1:0] ch_seen;

    // request decode and read-data mux
    always_comb begin
        bus_acc = ~cfg2scm_cs_n & scm2cfg_ack_n;
        bus_wr  = bus_acc & ~cfg2scm_rw;
        bus_rd  = bus_acc &  cfg2scm_rw;
        hi_ok   = (cfg2scm_addr[31:12] == '0);
        blk     = cfg2scm_addr[11:8];
        off     = cfg2scm_addr[7:0];
        g_sel   = hi_ok & (blk == 4'hF);
        clr_req = bus_wr & g_sel & (off == 8'h00) & cfg2scm_wdata[0];
        clr_rej = clr_req & ((state == S_RUN) | (state == S_GRACE));
        clr_ok  = clr_req & ~clr_rej;
        rd_mux  = 32'hDEAD_BEEF;
        if (g_sel) begin
            case (off)
                8'h00:   rd_mux = '0;
                8'h04:   rd_mux = {23'd0, clr_flag, 6'd0, state};
                8'h08:   rd_mux = n_rtt;
                default: ;
            endcase
        end
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (hi_ok && blk == 4'(c)) begin
                case (off)
                    8'h00:   rd_mux = {22'd0, ch_drop[c], ch_en[c], ch_proto[c]};
                    8'h04:   rd_mux = pkt_cnt[c][31:0];
                    8'h08:   rd_mux = pkt_cnt[c][63:32];
                    8'h0C:   rd_mux = byte_cnt[c][31:0];
                    8'h10:   rd_mux = byte_cnt[c][63:32];
                    8'h14:   rd_mux = last_ts[c] - first_ts[c];
                    default: ;
                endcase
            end
        end
    end

    // localbus handshake, configuration registers and clear-rejected flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scm2cfg_ack_n <= 1'b1;
            scm2cfg_rdata <= '0;
            n_rtt         <= '0;
            clr_flag      <= 1'b0;
            ch_en         <= '0;
            ch_drop       <= '0;
            for (int unsigned c = 0; c < CH_NUM; c++) ch_proto[c] <= '0;
        end else begin
            if (cfg2scm_cs_n)       scm2cfg_ack_n <= 1'b1;
            else if (scm2cfg_ack_n) scm2cfg_ack_n <= 1'b0;
            if (bus_rd) scm2cfg_rdata <= rd_mux;
            if (bus_wr && g_sel && off == 8'h08) n_rtt <= cfg2scm_wdata;
            if (clr_rej)
                clr_flag <= 1'b1;
            else if (bus_rd && g_sel && off == 8'h04)
                clr_flag <= 1'b0;
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                if (bus_wr && hi_ok && blk == 4'(c) && off == 8'h00) begin
                    ch_proto[c] <= cfg2scm_wdata[7:0];
                    ch_en[c]    <= cfg2scm_wdata[8];
                    ch_drop[c]  <= cfg2scm_wdata[9];
                end
            end
        end
    end

    // window FSM with end timestamp capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            end_ts       <= '0;
            last_lmid_ts <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gac2scm_sent_start) begin
                        state        <= S_RUN;
                        last_lmid_ts <= '0;
                    end
                end
                S_RUN: begin
                    if (lmid_pkt) last_lmid_ts <= h_ts;
                    if (gac2scm_sent_end) begin
                        state  <= S_GRACE;
                        end_ts <= lmid_pkt ? h_ts : last_lmid_ts;
                    end
                end
                S_GRACE: begin
                    if (grace_exit) state <= S_HOLD;
                end
                S_HOLD: begin
                    if (clr_ok) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (clr_ok) begin
                end_ts       <= '0;
                last_lmid_ts <= '0;
            end
        end
    end

    // per-channel packet/byte counters and timestamps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_seen <= '0;
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                pkt_cnt[c]  <= '0;
                byte_cnt[c] <= '0;
                first_ts[c] <= '0;
                last_ts[c]  <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                if (clr_ok) begin
                    pkt_cnt[c]  <= '0;
                    byte_cnt[c] <= '0;
                    first_ts[c] <= '0;
                    last_ts[c]  <= '0;
                    ch_seen[c]  <= 1'b0;
                end else if (ch_hit[c]) begin
                    pkt_cnt[c]  <= pkt_cnt[c] + 64'd1;
                    byte_cnt[c] <= byte_cnt[c] + {52'd0, h_len};
                    if (!ch_seen[c]) first_ts[c] <= h_ts;
                    ch_seen[c]  <= 1'b1;
                    last_ts[c]  <= h_ts;
                end
            end
        end
    end

endmodule

// File: tb/tb_scm_mstat.sv
// tb_scm_mstat: directed tables plus randomized windows checked against a
// packet-level model of the window and channel statistics.
module tb_scm_mstat;

    localparam int MD_W = 256;
    localparam int PHV_W = 1024;
    localparam logic [7:0] LMID_V = 8'd7;
    localparam logic [7:0] NMID_V = 8'd5;
    localparam int NCH = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [MD_W-1:0] in_md = '0, out_md;
    logic [PHV_W-1:0] in_phv = '0, out_phv;
    logic in_md_wr = 1'b0, in_phv_wr = 1'b0, in_md_alf = 1'b0, in_phv_alf = 1'b0;
    logic out_md_alf, out_phv_alf, out_md_wr, out_phv_wr;
    logic start = 1'b0, stop = 1'b0;
    logic cs_n = 1'b1, rw = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic ack_n;

    scm_mstat #(.MD_W(MD_W), .PHV_W(PHV_W), .LMID(LMID_V), .NMID(NMID_V),
                .CH_NUM(NCH), .FIFO_AW(8), .ALF_TH(250)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_md(in_md), .in_md_wr(in_md_wr), .out_md_alf(out_md_alf),
        .in_phv(in_phv), .in_phv_wr(in_phv_wr), .out_phv_alf(out_phv_alf),
        .out_md(out_md), .out_md_wr(out_md_wr), .in_md_alf(in_md_alf),
        .out_phv(out_phv), .out_phv_wr(out_phv_wr), .in_phv_alf(in_phv_alf),
        .gac2scm_sent_start(start), .gac2scm_sent_end(stop),
        .cfg2scm_cs_n(cs_n), .cfg2scm_rw(rw), .cfg2scm_addr(addr),
        .cfg2scm_wdata(wdata), .scm2cfg_ack_n(ack_n), .scm2cfg_rdata(rdata));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    int          mst = 0;             // 0 idle, 1 run, 2 grace, 3 hold
    logic        m_rej = 1'b0;
    logic [31:0] m_end_ts = '0, m_last_lmid = '0, m_nrtt = '0;
    logic        m_en [NCH], m_drop [NCH], m_seen [NCH];
    logic [7:0]  m_proto [NCH];
    logic [63:0] m_pkt [NCH], m_byte [NCH];
    logic [31:0] m_first [NCH], m_lastts [NCH];

    logic [MD_W-1:0]  q_md [$];
    logic [PHV_W-1:0] q_phv [$];
    int out_cnt = 0;
    int out_cyc [$];
    logic [MD_W-1:0] last_out_md = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mst = 0; m_rej = 0; m_end_ts = 0; m_last_lmid = 0; m_nrtt = 0;
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_drop[c] = 0; m_proto[c] = 0;
            m_pkt[c] = 0; m_byte[c] = 0; m_first[c] = 0; m_lastts[c] = 0; m_seen[c] = 0;
        end
    endtask

    task automatic model_clear();
        if (mst == 1 || mst == 2) m_rej = 1;
        else begin
            for (int c = 0; c < NCH; c++) begin
                m_pkt[c] = 0; m_byte[c] = 0; m_first[c] = 0; m_lastts[c] = 0; m_seen[c] = 0;
            end
            m_last_lmid = 0; m_end_ts = 0;
            if (mst == 3) mst = 0;
        end
    endtask

    // what the stage must emit for one packet, updating the statistics
    task automatic model_pkt(input logic [MD_W-1:0] md, output logic [MD_W-1:0] exp);
        logic [31:0] ts;
        logic counting, drop;
        ts = md[31:0];
        exp = md;
        counting = 0;
        drop = 0;
        if (md[87:80] == LMID_V) begin
            if (mst == 1) begin
                counting = 1;
                m_last_lmid = ts;
            end else if (mst == 2) begin
                if ({1'b0, ts} >= {1'b0, m_end_ts} + {1'b0, m_nrtt}) mst = 3;
                else counting = 1;
            end
            for (int c = 0; c < NCH; c++) begin
                if (counting && m_en[c] && m_proto[c] == md[79:72]) begin
                    m_pkt[c] += 1;
                    m_byte[c] += {52'd0, md[107:96]};
                    if (!m_seen[c]) m_first[c] = ts;
                    m_seen[c] = 1;
                    m_lastts[c] = ts;
                    drop |= m_drop[c];
                end
            end
            exp[87:80] = NMID_V;
            if (drop) exp[108] = 1'b1;
        end
    endtask

    // output monitor
    always @(negedge clk) begin
        logic [MD_W-1:0] e_md;
        logic [PHV_W-1:0] e_phv;
        if (rst_n && (out_md_wr || out_phv_wr)) begin
            chk("wr_pair", {63'd0, out_md_wr}, {63'd0, out_phv_wr});
            if (q_md.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_out: output with nothing queued md=%h", out_md);
            end else begin
                e_phv = q_phv.pop_front();
                model_pkt(q_md.pop_front(), e_md);
                checks++;
                if (out_md !== e_md) begin
                    failures++;
                    $display("FAIL out_md: got %h expected %h", out_md, e_md);
                end
                chk("out_phv", out_phv[63:0] ^ out_phv[PHV_W-1:PHV_W-64], e_phv[63:0] ^ e_phv[PHV_W-1:PHV_W-64]);
                checks++;
                if (out_phv !== e_phv) begin
                    failures++;
                    $display("FAIL out_phv_full: low word got %h expected %h", out_phv[63:0], e_phv[63:0]);
                end
            end
            last_out_md = out_md;
            out_cnt++;
            out_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [MD_W-1:0] mkmd(input logic [7:0] id, input logic [7:0] proto,
                                             input logic [11:0] len, input logic [31:0] ts);
        logic [MD_W-1:0] m;
        for (int i = 0; i < MD_W / 32; i++) m[i*32 +: 32] = $urandom;
        m[31:0] = ts; m[79:72] = proto; m[87:80] = id; m[107:96] = len;
        return m;
    endfunction

    function automatic logic [PHV_W-1:0] mkphv();
        logic [PHV_W-1:0] p;
        for (int i = 0; i < PHV_W / 32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic put(input logic [MD_W-1:0] md);
        in_md = md; in_phv = mkphv();
        in_md_wr = 1; in_phv_wr = 1;
        q_md.push_back(md); q_phv.push_back(in_phv);
        @(negedge clk);
        in_md_wr = 0; in_phv_wr = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q_md.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain", 64'(q_md.size()), 64'd0);
    endtask

    task automatic bus(input logic wr_n, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
        int lat;
        cs_n = 0; rw = wr_n; addr = a; wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ack_n && lat < 10);
        chk("ack_latency", 64'(lat), 64'd1);
        r = rdata;
        cs_n = 1;
        @(negedge clk);
        chk("ack_release", {63'd0, ack_n}, 64'd1);
    endtask

    task automatic bwr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b0, a, d, r);
    endtask

    task automatic brd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b1, a, 32'd0, r);
        chk(name, {32'd0, r}, {32'd0, exp});
    endtask

    task automatic set_ch(input int c, input logic en, input logic drop, input logic [7:0] proto);
        bwr(32'(c) << 8, {22'd0, drop, en, proto});
        m_en[c] = en; m_drop[c] = drop; m_proto[c] = proto;
    endtask

    task automatic set_nrtt(input logic [31:0] v);
        bwr(32'h0F08, v);
        m_nrtt = v;
    endtask

    task automatic do_clear();
        bwr(32'h0F00, 32'd1);
        model_clear();
    endtask

    task automatic chk_status();
        brd_chk("status", 32'h0F04, {23'd0, m_rej, 6'd0, 2'(mst)});
        m_rej = 0;
    endtask

    task automatic chk_ch(input int c);
        brd_chk("ch_cfg", 32'(c) << 8, {22'd0, m_drop[c], m_en[c], m_proto[c]});
        brd_chk("pkt_lo", (32'(c) << 8) | 32'h04, m_pkt[c][31:0]);
        brd_chk("pkt_hi", (32'(c) << 8) | 32'h08, m_pkt[c][63:32]);
        brd_chk("byte_lo", (32'(c) << 8) | 32'h0C, m_byte[c][31:0]);
        brd_chk("byte_hi", (32'(c) << 8) | 32'h10, m_byte[c][63:32]);
        brd_chk("elapsed", (32'(c) << 8) | 32'h14, m_lastts[c] - m_first[c]);
    endtask

    task automatic pulse_start();
        start = 1; @(negedge clk); start = 0;
        if (mst == 0) begin mst = 1; m_last_lmid = 0; end
    endtask

    task automatic pulse_end();
        stop = 1; @(negedge clk); stop = 0;
        if (mst == 1) begin mst = 2; m_end_ts = m_last_lmid; end
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp;
    } rv_t;

    // ---------------- test sequence ----------------
    initial begin
        rv_t tbl [12];
        logic [MD_W-1:0] md;
        logic [31:0] ts;
        int p0, first, bad;

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_md", {63'd0, |out_md}, 64'd0);
        chk("rst_out_phv", {63'd0, |out_phv}, 64'd0);
        chk("rst_out_wr", {62'd0, out_md_wr, out_phv_wr}, 64'd0);
        chk("rst_alf", {62'd0, out_md_alf, out_phv_alf}, 64'd0);
        chk("rst_ack_n", {63'd0, ack_n}, 64'd1);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        rst_n = 1;
        @(negedge clk);
        chk_status();

        // bypass, back-to-back, window idle
        p0 = cyc;
        first = out_cyc.size();
        for (int i = 0; i < 5; i++) put(mkmd(8'd3, 8'(i), 12'(64 + i), $urandom));
        drain();
        chk("bypass_latency", 64'(out_cyc[first] - p0), 64'd2);
        chk("bypass_throughput", 64'(out_cyc[first+4] - out_cyc[first]), 64'd4);
        brd_chk("bypass_pkt0", 32'h0004, 32'd0);

        // retag and count
        set_ch(0, 1'b1, 1'b0, 8'h01);
        set_nrtt(32'd50);
        pulse_start();
        for (int i = 1; i <= 4; i++) put(mkmd(LMID_V, 8'h01, 12'd100, 32'(10 * i)));
        drain();
        tbl[0]  = '{"t_pkt_lo",   32'h0004, 32'd4};
        tbl[1]  = '{"t_pkt_hi",   32'h0008, 32'd0};
        tbl[2]  = '{"t_byte_lo",  32'h000C, 32'd400};
        tbl[3]  = '{"t_byte_hi",  32'h0010, 32'd0};
        tbl[4]  = '{"t_elapsed",  32'h0014, 32'd30};
        tbl[5]  = '{"t_cfg0",     32'h0000, 32'h101};
        tbl[6]  = '{"t_ch1_pkt",  32'h0104, 32'd0};
        tbl[7]  = '{"t_status",   32'h0F04, 32'd1};
        tbl[8]  = '{"t_nrtt",     32'h0F08, 32'd50};
        tbl[9]  = '{"t_unmapped", 32'h0F0C, 32'hDEADBEEF};
        tbl[10] = '{"t_ch_range", 32'h0404, 32'hDEADBEEF};
        tbl[11] = '{"t_hi_addr",  32'h1000, 32'hDEADBEEF};
        for (int i = 0; i < 12; i++) brd_chk(tbl[i].name, tbl[i].addr, tbl[i].exp);

        // clear while running is rejected and sticky until read
        do_clear();
        brd_chk("clr_rej_status", 32'h0F04, 32'h101);
        brd_chk("clr_rej_reread", 32'h0F04, 32'h001);
        m_rej = 0;
        brd_chk("clr_rej_kept", 32'h0004, 32'd4);

        // grace: end_ts=40, n_rtt=50 -> threshold 90
        pulse_end();
        put(mkmd(LMID_V, 8'h01, 12'd100, 32'd60));
        put(mkmd(LMID_V, 8'h01, 12'd100, 32'd89));
        put(mkmd(LMID_V, 8'h01, 12'd100, 32'd90));
        drain();
        brd_chk("grace_status", 32'h0F04, 32'd3);
        brd_chk("grace_pkt", 32'h0004, 32'd6);
        brd_chk("grace_byte", 32'h000C, 32'd600);
        brd_chk("grace_elapsed", 32'h0014, 32'd79);
        chk_ch(0);

        // clear in HOLD
        do_clear();
        brd_chk("clr_status", 32'h0F04, 32'd0);
        brd_chk("clr_pkt", 32'h0004, 32'd0);
        brd_chk("clr_cfg_kept", 32'h0000, 32'h101);

        // multi-match with drop
        set_ch(0, 1'b1, 1'b0, 8'h02);
        set_ch(1, 1'b1, 1'b1, 8'h02);
        pulse_start();
        md = mkmd(LMID_V, 8'h02, 12'd77, 32'd100);
        md[108] = 1'b0;
        put(md);
        drain();
        chk("drop_bit", {63'd0, last_out_md[108]}, 64'd1);
        brd_chk("mm_ch0", 32'h0004, 32'd1);
        brd_chk("mm_ch1", 32'h0104, 32'd1);
        pulse_end();
        repeat (5) @(negedge clk);
        brd_chk("grace_no_traffic", 32'h0F04, 32'd2);
        put(mkmd(LMID_V, 8'h02, 12'd5, 32'd150));
        drain();
        chk_status();
        chk_ch(1);
        do_clear();

        // backpressure
        in_md_alf = 1;
        for (int i = 0; i < 8; i++) put(mkmd(8'd3, 8'h01, 12'd10, $urandom));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_md_wr || out_phv_wr) bad++;
        end
        chk("bp_hold", 64'(bad), 64'd0);
        chk("bp_alf", {62'd0, out_md_alf, out_phv_alf}, 64'd2);
        p0 = out_cnt;
        in_md_alf = 0;
        drain();
        chk("bp_count", 64'(out_cnt - p0), 64'd8);

        // almost-full threshold: 250 entries not above, 251 above
        in_phv_alf = 1;
        for (int i = 0; i < 250; i++) put(mkmd(8'd3, 8'h00, 12'd1, 32'(i)));
        chk("alf_250", {63'd0, out_md_alf}, 64'd0);
        put(mkmd(8'd3, 8'h00, 12'd1, 32'd250));
        chk("alf_251", {63'd0, out_md_alf}, 64'd1);
        in_phv_alf = 0;
        drain();

        // randomized windows
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NCH; c++)
                set_ch(c, ($urandom % 4) != 0, ($urandom % 3) == 0, 8'(1 + $urandom % 3));
            set_nrtt(32'(1 + $urandom % 60));
            pulse_start();
            ts = $urandom % 1000;
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom % 3) @(negedge clk);
                in_phv_alf = ($urandom % 5) == 0;
                if ($urandom % 10 < 7) put(mkmd(LMID_V, 8'(1 + $urandom % 3), 12'($urandom), ts));
                else put(mkmd(8'($urandom % 6), 8'(1 + $urandom % 3), 12'($urandom), $urandom));
                ts += 1 + $urandom % 20;
            end
            in_phv_alf = 0;
            drain();
            pulse_end();
            for (int k = 0; k < 60 && mst != 3; k++) begin
                put(mkmd(LMID_V, 8'(1 + $urandom % 3), 12'($urandom), ts));
                ts += 1 + $urandom % 20;
                drain();
            end
            chk_status();
            for (int c = 0; c < NCH; c++) chk_ch(c);
            do_clear();
            chk_status();
        end

        // reset mid-operation flushes FIFOs and statistics
        set_ch(2, 1'b1, 1'b0, 8'h03);
        in_md_alf = 1;
        for (int i = 0; i < 3; i++) put(mkmd(8'd3, 8'h01, 12'd10, $urandom));
        rst_n = 0;
        @(negedge clk);
        q_md.delete(); q_phv.delete();
        model_reset();
        rst_n = 1;
        in_md_alf = 0;
        p0 = out_cnt;
        repeat (10) @(negedge clk);
        chk("rst_flush", 64'(out_cnt - p0), 64'd0);
        chk_status();
        chk_ch(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
